// File: rtl/d7_eq_solver.sv
// Streaming calibration-equation solver: parses "target: a b c" lines from an ASCII
// byte stream, searches operator combinations, and sums the targets of solvable lines.
module d7_eq_solver #(
  parameter int MAX_OPERANDS = 12,
  parameter int VAL_W        = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       read_val,
  input  logic             read_val_valid,
  output logic             read_val_ready,
  input  logic             read_val_done,
  input  logic             concat_en,
  output logic [VAL_W-1:0] output_data,
  output logic             output_data_valid,
  output logic [15:0]      solved_count,
  output logic             err_overflow
);

  localparam int N_W   = $clog2(MAX_OPERANDS + 1);
  localparam int C_N   = 2 ** N_W;
  localparam int DIG_W = 6;
  localparam int DIG_N = 2 ** DIG_W;

  typedef enum logic [2:0] {PARSE_TGT, PARSE_OPS, EVAL, CHECK, DONE} state_t;

  // Returns {overflow, 10^k}; overflow means 10^k does not fit in VAL_W bits.
  function automatic logic [VAL_W:0] pow10_f(input int k);
    logic [VAL_W+3:0] t;
    logic             ovf;
    t   = {{(VAL_W+3){1'b0}}, 1'b1};
    ovf = 1'b0;
    for (int j = 0; j < k; j++) begin
      t = t * (VAL_W+4)'(10);
      if (t[VAL_W+3:VAL_W] != 4'b0000) begin
        ovf               = 1'b1;
        t[VAL_W+3:VAL_W]  = 4'b0000;
      end else begin
        ovf = ovf;
      end
    end
    return {ovf, t[VAL_W-1:0]};
  endfunction

  function automatic logic [2*C_N-1:0] combo_inc(input logic [2*C_N-1:0] c, input logic [1:0] maxd);
    logic [2*C_N-1:0] r;
    logic             carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < C_N; i++) begin
      if (carry) begin
        if (r[2*i +: 2] == maxd) begin
          r[2*i +: 2] = 2'd0;
        end else begin
          r[2*i +: 2] = r[2*i +: 2] + 2'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  logic [VAL_W:0] pow_tab_s [DIG_N];
  for (genvar k = 0; k < DIG_N; k++) begin : g_pow
    assign pow_tab_s[k] = pow10_f(k);
  end

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   target_q, target_d;
  logic [VAL_W-1:0]   ops_q [MAX_OPERANDS];
  logic [VAL_W-1:0]   ops_d [MAX_OPERANDS];
  logic [DIG_W-1:0]   digs_q [MAX_OPERANDS];
  logic [DIG_W-1:0]   digs_d [MAX_OPERANDS];
  logic [N_W-1:0]     n_q, n_d, idx_q, idx_d;
  logic [VAL_W-1:0]   cur_q, cur_d, acc_q, acc_d, sum_q, sum_d;
  logic [DIG_W-1:0]   cur_dig_q, cur_dig_d;
  logic               pend_q, pend_d, has_zero_q, has_zero_d, line_ovf_q, line_ovf_d;
  logic               active_q, active_d, cat_q, cat_d, done_q, done_d;
  logic               valid_q, valid_d, err_q, err_d, ready_q, ready_d;
  logic [2*C_N-1:0]   combo_q, combo_d;
  logic [15:0]        solved_q, solved_d;

  logic               accept_s, done_s, is_digit_s, close_s, eol_s, end_line_s, last_s;
  logic [1:0]         maxd_s, opc_s;
  logic [N_W-1:0]     opi_s;
  logic [VAL_W-1:0]   op_i_s, mul_b_s, base_s, addend_s;
  logic [DIG_W-1:0]   d_eff_s;
  logic [VAL_W:0]     pow_s, res_s;
  logic [2*VAL_W-1:0] prod_s;
  logic               ovf_s, prune_s;

  assign accept_s   = read_val_valid & ready_q;
  assign done_s     = read_val_done & ready_q;
  assign is_digit_s = (read_val >= 8'h30) && (read_val <= 8'h39);
  assign maxd_s     = cat_q ? 2'd2 : 2'd1;

  // One operator step: a shared multiplier serves both '*' and the concat shift.
  assign opi_s    = idx_q - {{(N_W-1){1'b0}}, 1'b1};
  assign opc_s    = combo_q[{opi_s, 1'b0} +: 2];
  assign op_i_s   = ops_q[idx_q];
  assign d_eff_s  = (digs_q[idx_q] == {DIG_W{1'b0}}) ? {{(DIG_W-1){1'b0}}, 1'b1} : digs_q[idx_q];
  assign pow_s    = pow_tab_s[d_eff_s];
  assign mul_b_s  = (opc_s == 2'd1) ? op_i_s : pow_s[VAL_W-1:0];
  assign prod_s   = {{VAL_W{1'b0}}, acc_q} * {{VAL_W{1'b0}}, mul_b_s};
  assign base_s   = (opc_s == 2'd0) ? acc_q : prod_s[VAL_W-1:0];
  assign addend_s = (opc_s == 2'd1) ? {VAL_W{1'b0}} : op_i_s;
  assign res_s    = {1'b0, base_s} + {1'b0, addend_s};
  assign ovf_s    = res_s[VAL_W]
                  | ((opc_s != 2'd0) & (prod_s[2*VAL_W-1:VAL_W] != {VAL_W{1'b0}}))
                  | ((opc_s == 2'd2) & pow_s[VAL_W] & (acc_q != {VAL_W{1'b0}}));
  assign prune_s  = ovf_s | (~has_zero_q & (res_s[VAL_W-1:0] > target_q));

  // Last combination: every active operator digit is at its maximum value.
  always_comb begin
    last_s = 1'b1;
    for (int i = 0; i < C_N; i++) begin
      last_s = last_s & ~((i + 1 < int'(n_q)) & (combo_q[2*i +: 2] != maxd_s));
    end
  end

  // Next-state logic: byte parsing, line finalisation, search and accumulation.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    ops_d      = ops_q;
    digs_d     = digs_q;
    n_d        = n_q;
    cur_d      = cur_q;
    cur_dig_d  = cur_dig_q;
    pend_d     = pend_q;
    has_zero_d = has_zero_q;
    line_ovf_d = line_ovf_q;
    active_d   = active_q;
    cat_d      = cat_q;
    combo_d    = combo_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    done_d     = done_q;
    sum_d      = sum_q;
    solved_d   = solved_q;
    err_d      = err_q;
    close_s    = 1'b0;
    eol_s      = 1'b0;
    end_line_s = 1'b0;

    case (state_q)
      PARSE_TGT: begin
        if (accept_s) begin
          if (!active_q) begin
            cat_d    = concat_en;
            active_d = 1'b1;
          end else begin
            cat_d = cat_q;
          end
          if (is_digit_s) begin
            target_d = target_q * VAL_W'(10) + VAL_W'(read_val[3:0]);
          end else if (read_val == 8'h3A) begin
            state_d = PARSE_OPS;
          end else if (read_val == 8'h0A) begin
            end_line_s = 1'b1;
          end else begin
            target_d = target_q;
          end
        end else begin
          target_d = target_q;
        end
        if (done_s) begin
          done_d = 1'b1;
          if (state_d == PARSE_OPS) begin
            eol_s = 1'b1;
          end else begin
            end_line_s = 1'b1;
          end
        end else begin
          done_d = done_q;
        end
      end
      PARSE_OPS: begin
        if (accept_s) begin
          if (is_digit_s) begin
            cur_d     = cur_q * VAL_W'(10) + VAL_W'(read_val[3:0]);
            cur_dig_d = (cur_dig_q == {DIG_W{1'b1}}) ? cur_dig_q : cur_dig_q + {{(DIG_W-1){1'b0}}, 1'b1};
            pend_d    = 1'b1;
          end else if (read_val == 8'h20) begin
            close_s = 1'b1;
          end else if (read_val == 8'h0A) begin
            close_s = 1'b1;
            eol_s   = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end else begin
          pend_d = pend_q;
        end
        if (done_s) begin
          done_d  = 1'b1;
          close_s = 1'b1;
          eol_s   = 1'b1;
        end else begin
          done_d = done_q;
        end
      end
      EVAL: begin
        if (prune_s) begin
          if (last_s) begin
            end_line_s = 1'b1;
          end else begin
            combo_d = combo_inc(combo_q, maxd_s);
            acc_d   = ops_q[0];
            idx_d   = {{(N_W-1){1'b0}}, 1'b1};
          end
        end else if (idx_q == n_q - {{(N_W-1){1'b0}}, 1'b1}) begin
          acc_d   = res_s[VAL_W-1:0];
          state_d = CHECK;
        end else begin
          acc_d = res_s[VAL_W-1:0];
          idx_d = idx_q + {{(N_W-1){1'b0}}, 1'b1};
        end
      end
      CHECK: begin
        if (acc_q == target_q) begin
          sum_d      = sum_q + target_q;
          solved_d   = solved_q + 16'd1;
          end_line_s = 1'b1;
        end else if (last_s) begin
          end_line_s = 1'b1;
        end else begin
          combo_d = combo_inc(combo_q, maxd_s);
          acc_d   = ops_q[0];
          idx_d   = {{(N_W-1){1'b0}}, 1'b1};
          state_d = EVAL;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = PARSE_TGT;
      end
    endcase

    // Operands past the storage limit are consumed but flag the line as unsolvable.
    if (close_s && pend_d) begin
      if (n_d < N_W'(MAX_OPERANDS)) begin
        ops_d[n_d]  = cur_d;
        digs_d[n_d] = cur_dig_d;
        has_zero_d  = has_zero_d | (cur_d == {VAL_W{1'b0}});
        n_d         = n_d + {{(N_W-1){1'b0}}, 1'b1};
      end else begin
        line_ovf_d = 1'b1;
        err_d      = 1'b1;
      end
      cur_d     = {VAL_W{1'b0}};
      cur_dig_d = {DIG_W{1'b0}};
      pend_d    = 1'b0;
    end else begin
      pend_d = pend_d;
    end

    if (eol_s) begin
      if (line_ovf_d || (n_d == {N_W{1'b0}})) begin
        end_line_s = 1'b1;
      end else begin
        acc_d   = ops_d[0];
        idx_d   = {{(N_W-1){1'b0}}, 1'b1};
        combo_d = {(2*C_N){1'b0}};
        state_d = (n_d == {{(N_W-1){1'b0}}, 1'b1}) ? CHECK : EVAL;
      end
    end else begin
      acc_d = acc_d;
    end

    if (end_line_s) begin
      state_d    = done_d ? DONE : PARSE_TGT;
      target_d   = {VAL_W{1'b0}};
      n_d        = {N_W{1'b0}};
      cur_d      = {VAL_W{1'b0}};
      cur_dig_d  = {DIG_W{1'b0}};
      pend_d     = 1'b0;
      has_zero_d = 1'b0;
      line_ovf_d = 1'b0;
      active_d   = 1'b0;
    end else begin
      active_d = active_d;
    end

    valid_d = valid_q | (state_d == DONE);
    ready_d = (state_d == PARSE_TGT) || (state_d == PARSE_OPS);
  end

  // State register with asynchronous clear of the whole datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PARSE_TGT;
      target_q   <= {VAL_W{1'b0}};
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        ops_q[i]  <= {VAL_W{1'b0}};
        digs_q[i] <= {DIG_W{1'b0}};
      end
      n_q        <= {N_W{1'b0}};
      idx_q      <= {N_W{1'b0}};
      cur_q      <= {VAL_W{1'b0}};
      cur_dig_q  <= {DIG_W{1'b0}};
      pend_q     <= 1'b0;
      has_zero_q <= 1'b0;
      line_ovf_q <= 1'b0;
      active_q   <= 1'b0;
      cat_q      <= 1'b0;
      combo_q    <= {(2*C_N){1'b0}};
      acc_q      <= {VAL_W{1'b0}};
      done_q     <= 1'b0;
      sum_q      <= {VAL_W{1'b0}};
      solved_q   <= 16'd0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      ops_q      <= ops_d;
      digs_q     <= digs_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      cur_dig_q  <= cur_dig_d;
      pend_q     <= pend_d;
      has_zero_q <= has_zero_d;
      line_ovf_q <= line_ovf_d;
      active_q   <= active_d;
      cat_q      <= cat_d;
      combo_q    <= combo_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      solved_q   <= solved_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign read_val_ready    = ready_q;
  assign output_data       = sum_q;
  assign output_data_valid = valid_q;
  assign solved_count      = solved_q;
  assign err_overflow      = err_q;

endmodule

// File: tb/tb_d7_eq_solver.sv
// Directed bench for d7_eq_solver: streams ASCII lines and compares the final
// sum, solved count and overflow flag against hand-computed answers.
module tb_d7_eq_solver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  read_val;
  logic        read_val_valid;
  logic        read_val_ready;
  logic        read_val_done;
  logic        concat_en;
  logic [63:0] output_data;
  logic        output_data_valid;
  logic [15:0] solved_count;
  logic        err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  d7_eq_solver dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .read_val          (read_val),
    .read_val_valid    (read_val_valid),
    .read_val_ready    (read_val_ready),
    .read_val_done     (read_val_done),
    .concat_en         (concat_en),
    .output_data       (output_data),
    .output_data_valid (output_data_valid),
    .solved_count      (solved_count),
    .err_overflow      (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    read_val       = 8'h00;
    read_val_valid = 1'b0;
    read_val_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (!read_val_ready && cnt < 20000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!read_val_ready) check_eq("ready_timeout", 64'(read_val_ready), 64'd1);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit dn);
    wait_ready();
    read_val       = b;
    read_val_valid = 1'b1;
    read_val_done  = dn;
    @(posedge clk);
    #1;
    read_val_valid = 1'b0;
    read_val_done  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit done_last);
    for (int i = 0; i < s.len(); i++) begin
      put_byte(s[i], done_last && (i == s.len() - 1));
    end
  endtask

  task automatic end_stream();
    wait_ready();
    read_val_done = 1'b1;
    @(posedge clk);
    #1;
    read_val_done = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cnt = 0;
    while (!output_data_valid && cnt < 20000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq({name, "_valid"}, 64'(output_data_valid), 64'd1);
  endtask

  task automatic run_case(input string name, input bit cat, input string s,
                          input logic [63:0] exp_sum, input int exp_solved, input bit exp_err);
    do_reset();
    concat_en = cat;
    send_str(s, 1'b0);
    end_stream();
    wait_valid(name);
    check_eq({name, "_sum"}, output_data, exp_sum);
    check_eq({name, "_solved"}, 64'(solved_count), 64'(exp_solved));
    check_eq({name, "_err"}, 64'(err_overflow), 64'(exp_err));
  endtask

  localparam string AOC = {"190: 10 19\n", "3267: 81 40 27\n", "83: 17 5\n",
                           "156: 15 6\n", "7290: 6 8 6 15\n", "161011: 16 10 13\n",
                           "192: 17 8 14\n", "21037: 9 7 18 13\n", "292: 11 6 16 20\n"};

  initial begin
    int cnt;
    int rdy_hi;

    rst_n          = 1'b0;
    read_val       = 8'h00;
    read_val_valid = 1'b0;
    read_val_done  = 1'b0;
    concat_en      = 1'b0;
    #23;
    check_eq("rst_ready", 64'(read_val_ready), 64'd0);
    check_eq("rst_sum", output_data, 64'd0);
    check_eq("rst_valid", 64'(output_data_valid), 64'd0);
    check_eq("rst_solved", 64'(solved_count), 64'd0);
    check_eq("rst_err", 64'(err_overflow), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_eq("ready_before_edge", 64'(read_val_ready), 64'd0);
    @(posedge clk);
    #1 check_eq("ready_after_edge", 64'(read_val_ready), 64'd1);

    run_case("l190", 1'b0, "190: 10 19\n", 64'd190, 1, 1'b0);
    run_case("l156_add_mul", 1'b0, "156: 15 6\n", 64'd0, 0, 1'b0);
    run_case("l156_cat", 1'b1, "156: 15 6\n", 64'd156, 1, 1'b0);
    run_case("aoc_p1", 1'b0, AOC, 64'd3749, 3, 1'b0);
    run_case("aoc_p2", 1'b1, AOC, 64'd11387, 6, 1'b0);
    run_case("blank_cr", 1'b0, "\n\r\n190: 10 19\r\n", 64'd190, 1, 1'b0);
    run_case("zero_noprune", 1'b0, "5: 9 1 0 5\n190: 10 19\n", 64'd195, 2, 1'b0);
    run_case("partial_tgt", 1'b0, "190: 10 19\n12", 64'd190, 1, 1'b0);
    run_case("overflow", 1'b0, "13: 1 1 1 1 1 1 1 1 1 1 1 1 1\n190: 10 19\n",
             64'd190, 1, 1'b1);

    // Stream ends on the last digit with no newline; ready must stay low while solving.
    do_reset();
    concat_en = 1'b1;
    send_str("7290: 6 8 6 15", 1'b1);
    cnt    = 0;
    rdy_hi = 0;
    while (!output_data_valid && cnt < 2000) begin
      if (read_val_ready) rdy_hi++;
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("eof_valid", 64'(output_data_valid), 64'd1);
    check_eq("eof_ready_low", 64'(rdy_hi), 64'd0);
    check_eq("eof_min_latency", 64'(cnt >= 4), 64'd1);
    check_eq("eof_sum", output_data, 64'd7290);
    check_eq("eof_solved", 64'(solved_count), 64'd1);
    @(posedge clk);
    #1 check_eq("eof_done_ready", 64'(read_val_ready), 64'd0);

    // Reset pulsed while the second line is being searched.
    do_reset();
    concat_en = 1'b0;
    send_str("190: 10 19\n", 1'b0);
    send_str("3267: 81 40 27\n", 1'b0);
    @(posedge clk);
    #1;
    check_eq("mid_eval_ready", 64'(read_val_ready), 64'd0);
    check_eq("mid_eval_sum", output_data, 64'd190);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_sum", output_data, 64'd0);
    check_eq("mid_rst_solved", 64'(solved_count), 64'd0);
    check_eq("mid_rst_ready", 64'(read_val_ready), 64'd0);
    check_eq("mid_rst_valid", 64'(output_data_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_str("3267: 81 40 27\n", 1'b0);
    end_stream();
    wait_valid("refeed");
    check_eq("refeed_sum", output_data, 64'd3267);
    check_eq("refeed_solved", 64'(solved_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
